// File: rtl/control_unit_mc.sv
// -----------------------------------------------------------------------------
// control_unit_mc
//   Multi-cycle Moore control unit for a LD / SD / ADD / SUB datapath.
//   It accepts one 32-bit RV64 instruction per valid/ready handshake, then
//   walks it through DECODE -> EXEC -> (MEM) -> (WB). The data-memory wait
//   is bounded by MEM_TIMEOUT cycles. The unit reports retirement, illegal
//   encodings and memory aborts, and it keeps a wrapping retired-instruction
//   count.
//
// Ports
//   clk, rst_n          clock (posedge) and asynchronous active-low reset
//   instr_valid/ready   instruction handshake; ready only while idle
//   instruction         instruction word, latched on the handshake
//   dm_ready            data memory finished the current read/write
//   rf_addr_a/b         rs1 / rs2 register addresses
//   rf_write_addr       rd register address
//   rf_write_enable     register-file write strobe (suppressed for x0)
//   rf_wdata_sel        write-back source: 0 = ALU, 1 = memory
//   alu_op              0 = add, 1 = sub
//   alu_src_imm         ALU operand B: 0 = rs2, 1 = immediate
//   imm                 sign-extended immediate
//   dm_read             memory read request (LD)
//   dm_write_enable     memory write request (SD)
//   done                one-cycle pulse, instruction retired
//   illegal             one-cycle pulse, unsupported encoding
//   mem_timeout         one-cycle pulse, memory access aborted
//   retired_count       retired instructions, wraps
// -----------------------------------------------------------------------------
module control_unit_mc #(
    parameter int WORDSIZE    = 64,
    parameter int SIZE        = 32,
    parameter int RF_ADDR_W   = 5,
    parameter int DM_ADDR_W   = 5,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic [SIZE-1:0]      instruction,
    input  logic                 dm_ready,
    output logic [RF_ADDR_W-1:0] rf_addr_a,
    output logic [RF_ADDR_W-1:0] rf_addr_b,
    output logic [RF_ADDR_W-1:0] rf_write_addr,
    output logic                 rf_write_enable,
    output logic                 rf_wdata_sel,
    output logic                 alu_op,
    output logic                 alu_src_imm,
    output logic [WORDSIZE-1:0]  imm,
    output logic                 dm_read,
    output logic                 dm_write_enable,
    output logic                 done,
    output logic                 illegal,
    output logic                 mem_timeout,
    output logic [CNT_W-1:0]     retired_count
);

    // DM_ADDR_W only matters to the memory, which truncates the ALU result.
    // It is checked here so that a bad parameter set fails at elaboration.
    generate
        if (SIZE != 32 || MEM_TIMEOUT < 1 || DM_ADDR_W < 1 || WORDSIZE < 12) begin : g_param_check
            $error("control_unit_mc: unsupported parameter set");
        end
    endgenerate

    localparam int TW = $clog2(MEM_TIMEOUT + 1);

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [2:0] F3_D      = 3'b011;
    localparam logic [2:0] F3_ADD    = 3'b000;
    localparam logic [6:0] F7_ADD    = 7'b0000000;
    localparam logic [6:0] F7_SUB    = 7'b0100000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_ERR
    } state_t;

    state_t          state;
    logic [SIZE-1:0] instr_q;
    logic [TW-1:0]   tmo_cnt;

    function automatic logic [WORDSIZE-1:0] sext12(input logic signed [11:0] v);
        return WORDSIZE'(v);
    endfunction

    // Field decode of the latched instruction
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [6:0] funct7;
    logic       is_ld;
    logic       is_sd;
    logic       is_add;
    logic       is_sub;
    logic       legal;
    logic       tmo_hit;

    assign opcode = instr_q[6:0];
    assign rd     = instr_q[11:7];
    assign funct3 = instr_q[14:12];
    assign rs1    = instr_q[19:15];
    assign rs2    = instr_q[24:20];
    assign funct7 = instr_q[31:25];

    assign is_ld  = (opcode == OPC_LOAD)  && (funct3 == F3_D);
    assign is_sd  = (opcode == OPC_STORE) && (funct3 == F3_D);
    assign is_add = (opcode == OPC_OP) && (funct3 == F3_ADD) && (funct7 == F7_ADD);
    assign is_sub = (opcode == OPC_OP) && (funct3 == F3_ADD) && (funct7 == F7_SUB);
    assign legal  = is_ld | is_sd | is_add | is_sub;

    // tmo_cnt holds the number of MEM cycles that have already passed, so the
    // current MEM cycle is number tmo_cnt+1. The abort happens in that cycle
    // when its number equals MEM_TIMEOUT.
    assign tmo_hit = (tmo_cnt == TW'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            instr_q       <= '0;
            tmo_cnt       <= '0;
            retired_count <= '0;
        end else begin
            if (done)
                retired_count <= retired_count + CNT_W'(1);
            case (state)
                S_IDLE: begin
                    if (instr_valid) begin
                        instr_q <= instruction;
                        state   <= S_DECODE;
                    end
                end
                S_DECODE: state <= legal ? S_EXEC : S_ERR;
                S_EXEC: begin
                    if (is_ld || is_sd) begin
                        tmo_cnt <= '0;
                        state   <= S_MEM;
                    end else begin
                        state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dm_ready)
                        state <= is_ld ? S_WB : S_IDLE;
                    else if (tmo_hit)
                        state <= S_IDLE;
                    else
                        tmo_cnt <= tmo_cnt + TW'(1);
                end
                S_WB:    state <= S_IDLE;
                S_ERR:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Outputs are decoded from state and instr_q. The only exceptions are the
    // SD completion and the timeout pulse. These fire in the MEM cycle that
    // sees dm_ready (or does not see it), so they also depend on dm_ready.
    always_comb begin
        instr_ready     = (state == S_IDLE);
        rf_addr_a       = '0;
        rf_addr_b       = '0;
        rf_write_addr   = '0;
        rf_write_enable = 1'b0;
        rf_wdata_sel    = 1'b0;
        alu_op          = 1'b0;
        alu_src_imm     = 1'b0;
        imm             = '0;
        dm_read         = 1'b0;
        dm_write_enable = 1'b0;
        done            = 1'b0;
        illegal         = 1'b0;
        mem_timeout     = 1'b0;

        if (state != S_IDLE) begin
            rf_addr_a     = RF_ADDR_W'(rs1);
            rf_addr_b     = RF_ADDR_W'(rs2);
            rf_write_addr = RF_ADDR_W'(rd);
            if (is_ld)
                imm = sext12(instr_q[31:20]);
            else if (is_sd)
                imm = sext12({instr_q[31:25], instr_q[11:7]});
        end

        if (state == S_EXEC || state == S_MEM || state == S_WB) begin
            alu_op       = is_sub;
            alu_src_imm  = is_ld | is_sd;
            rf_wdata_sel = is_ld;
        end

        case (state)
            S_MEM: begin
                dm_read         = is_ld;
                dm_write_enable = is_sd;
                done            = is_sd & dm_ready;
                mem_timeout     = ~dm_ready & tmo_hit;
            end
            S_WB: begin
                rf_write_enable = (rd != 5'd0);
                done            = 1'b1;
            end
            S_ERR:   illegal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit_mc.sv
// -----------------------------------------------------------------------------
// tb_control_unit_mc
//   Bench for control_unit_mc (CNT_W=4, MEM_TIMEOUT=6). For each instruction
//   the reference model builds the expected cycle-by-cycle trace. It derives
//   the trace from the instruction class and the chosen dm_ready delay, then
//   compares it against the DUT on the falling edge.
// -----------------------------------------------------------------------------
module tb_control_unit_mc;

    localparam int WS  = 64;
    localparam int SZ  = 32;
    localparam int AW  = 5;
    localparam int DW  = 5;
    localparam int TMO = 6;
    localparam int CW  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          instr_valid;
    logic          instr_ready;
    logic [SZ-1:0] instruction;
    logic          dm_ready;
    logic [AW-1:0] rf_addr_a;
    logic [AW-1:0] rf_addr_b;
    logic [AW-1:0] rf_write_addr;
    logic          rf_write_enable;
    logic          rf_wdata_sel;
    logic          alu_op;
    logic          alu_src_imm;
    logic [WS-1:0] imm;
    logic          dm_read;
    logic          dm_write_enable;
    logic          done;
    logic          illegal;
    logic          mem_timeout;
    logic [CW-1:0] retired_count;

    control_unit_mc #(
        .WORDSIZE(WS), .SIZE(SZ), .RF_ADDR_W(AW), .DM_ADDR_W(DW),
        .MEM_TIMEOUT(TMO), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instruction(instruction), .dm_ready(dm_ready),
        .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b),
        .rf_write_addr(rf_write_addr), .rf_write_enable(rf_write_enable),
        .rf_wdata_sel(rf_wdata_sel), .alu_op(alu_op), .alu_src_imm(alu_src_imm),
        .imm(imm), .dm_read(dm_read), .dm_write_enable(dm_write_enable),
        .done(done), .illegal(illegal), .mem_timeout(mem_timeout),
        .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    // ctl bit order: {ready, we, wsel, aop, asrc, dmr, dmw, done, ill, tmo}
    typedef struct packed {
        logic [9:0] ctl;
        logic       dc;    // DECODE cycle: ALU/wsel controls not yet defined
        logic       fld;   // addresses/imm must be valid this cycle
        logic       drdy;  // dm_ready to drive this cycle
    } exp_t;

    localparam logic [9:0] CTL_IDLE = 10'b10_0000_0000;
    localparam logic [9:0] DC_MASK  = 10'b11_0001_1111;

    exp_t q[$];
    int   n_cmp     = 0;
    int   n_bad     = 0;
    int   model_cnt = 0;

    function automatic exp_t mk(input logic [9:0] c, input logic dc, input logic fld, input logic dr);
        exp_t e;
        e.ctl  = c;
        e.dc   = dc;
        e.fld  = fld;
        e.drdy = dr;
        return e;
    endfunction

    function automatic logic [9:0] act_ctl();
        return {instr_ready, rf_write_enable, rf_wdata_sel, alu_op, alu_src_imm,
                dm_read, dm_write_enable, done, illegal, mem_timeout};
    endfunction

    // Reference model + driver. Entered and left in an IDLE cycle at negedge.
    // delay = number of dm_ready=0 MEM cycles before dm_ready=1.
    task automatic run_instr(input logic [31:0] ins, input int delay, input bit noise, input string tag);
        logic [6:0]  opc;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        bit          is_ld, is_sd, is_add, is_sub, legal, retire, nz;
        longint      iv;
        logic [63:0] eimm;
        logic [78:0] efld;
        logic [9:0]  m;
        logic [9:0]  a;
        opc = ins[6:0];   rd  = ins[11:7];  f3 = ins[14:12];
        rs1 = ins[19:15]; rs2 = ins[24:20]; f7 = ins[31:25];
        is_ld  = (opc == 7'h03) && (f3 == 3'd3);
        is_sd  = (opc == 7'h23) && (f3 == 3'd3);
        is_add = (opc == 7'h33) && (f3 == 3'd0) && (f7 == 7'h00);
        is_sub = (opc == 7'h33) && (f3 == 3'd0) && (f7 == 7'h20);
        legal  = is_ld || is_sd || is_add || is_sub;
        nz     = (rd != 5'd0);
        retire = 1'b0;
        iv = 0;
        if (is_ld) iv = longint'(ins[31:20]);
        else if (is_sd) iv = longint'({ins[31:25], ins[11:7]});
        if (iv >= 2048) iv = iv - 4096;
        eimm = iv;
        efld = {rs1, rs2, rd, eimm};

        q.delete();
        q.push_back(mk(10'b0, 1'b1, legal, 1'($urandom_range(0, 1))));
        if (!legal) begin
            q.push_back(mk(10'b00_0000_0010, 1'b0, 1'b0, 1'($urandom_range(0, 1))));
        end else if (is_add || is_sub) begin
            q.push_back(mk({3'b000, is_sub, 6'b0}, 1'b0, 1'b1, 1'($urandom_range(0, 1))));
            q.push_back(mk({1'b0, nz, 1'b0, is_sub, 3'b000, 1'b1, 2'b00}, 1'b0, 1'b1, 1'($urandom_range(0, 1))));
            retire = 1'b1;
        end else begin
            q.push_back(mk({2'b00, is_ld, 1'b0, 1'b1, 5'b0}, 1'b0, 1'b1, 1'($urandom_range(0, 1))));
            if (delay < TMO) begin
                for (int k = 0; k < delay; k++)
                    q.push_back(mk({2'b00, is_ld, 1'b0, 1'b1, is_ld, is_sd, 3'b000}, 1'b0, 1'b1, 1'b0));
                q.push_back(mk({2'b00, is_ld, 1'b0, 1'b1, is_ld, is_sd, is_sd, 2'b00}, 1'b0, 1'b1, 1'b1));
                if (is_ld)
                    q.push_back(mk({1'b0, nz, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 2'b00}, 1'b0, 1'b1, 1'($urandom_range(0, 1))));
                retire = 1'b1;
            end else begin
                for (int k = 0; k < TMO; k++)
                    q.push_back(mk({2'b00, is_ld, 1'b0, 1'b1, is_ld, is_sd, 2'b00, (k == TMO - 1)}, 1'b0, 1'b1, 1'b0));
            end
        end
        if (retire) model_cnt = (model_cnt + 1) % (1 << CW);

        instruction = ins;
        instr_valid = 1'b1;
        @(posedge clk);
        foreach (q[i]) begin
            #1;
            dm_ready = q[i].drdy;
            if (noise) begin
                instr_valid = 1'b1;
                instruction = $urandom;
            end else begin
                instr_valid = 1'b0;
            end
            @(negedge clk);
            m = q[i].dc ? DC_MASK : 10'h3FF;
            a = act_ctl();
            n_cmp++;
            if ((a & m) !== (q[i].ctl & m)) begin
                n_bad++;
                $display("FAIL %s ctl cycle %0d: got %b expected %b", tag, i + 1, a & m, q[i].ctl & m);
            end
            if (q[i].fld) begin
                n_cmp++;
                if ({rf_addr_a, rf_addr_b, rf_write_addr, imm} !== efld) begin
                    n_bad++;
                    $display("FAIL %s fields cycle %0d: got a=%0d b=%0d w=%0d imm=%h expected a=%0d b=%0d w=%0d imm=%h",
                             tag, i + 1, rf_addr_a, rf_addr_b, rf_write_addr, imm, rs1, rs2, rd, eimm);
                end
            end
            @(posedge clk);
        end
        #1;
        instr_valid = 1'b0;
        dm_ready    = 1'($urandom_range(0, 1));
        @(negedge clk);
        n_cmp++;
        if (act_ctl() !== CTL_IDLE) begin
            n_bad++;
            $display("FAIL %s idle ctl: got %b expected %b", tag, act_ctl(), CTL_IDLE);
        end
        n_cmp++;
        if (retired_count !== CW'(model_cnt)) begin
            n_bad++;
            $display("FAIL %s count: got %0d expected %0d", tag, retired_count, model_cnt);
        end
    endtask

    function automatic logic [31:0] rand_instr(input int kind);
        logic [31:0] r;
        r = $urandom;
        case (kind)
            0: r = {r[31:15], 3'b011, r[11:7], 7'b0000011};
            1: r = {r[31:15], 3'b011, r[11:7], 7'b0100011};
            2: r = {7'b0000000, r[24:15], 3'b000, r[11:7], 7'b0110011};
            3: r = {7'b0100000, r[24:15], 3'b000, r[11:7], 7'b0110011};
            4: r = {r[31:15], 3'b010, r[11:7], 7'b0000011};
            5: r = {7'b0000001, r[24:15], 3'b000, r[11:7], 7'b0110011};
            default: ;
        endcase
        return r;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_cnt = 0;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instruction = '0;
        dm_ready    = 1'b0;
        #12;
        n_cmp++;
        if ({act_ctl(), rf_addr_a, rf_addr_b, rf_write_addr, imm, retired_count} !== {CTL_IDLE, 79'b0, CW'(0)}) begin
            n_bad++;
            $display("FAIL reset outputs: ctl=%b imm=%h cnt=%0d expected ctl=%b, rest 0", act_ctl(), imm, retired_count, CTL_IDLE);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_cnt = 0;
        @(negedge clk);
    endtask

    task automatic test_add_sub();
        run_instr(32'h002081B3, 0, 1'b0, "add_x3");
        run_instr(32'h407302B3, 0, 1'b0, "sub_x5");
        run_instr(32'h00208033, 0, 1'b0, "add_x0");
    endtask

    task automatic test_ld();
        run_instr(32'hFF813203, 3, 1'b0, "ld_x4_delay3");
        run_instr(32'hFF813203, 0, 1'b0, "ld_x4_fast");
        run_instr(32'hFF813203, TMO - 1, 1'b0, "ld_last_chance");
    endtask

    task automatic test_sd_timeout();
        run_instr(32'h0050B823, 1000, 1'b0, "sd_timeout");
        run_instr(32'h0050B823, 0, 1'b0, "sd_fast");
        run_instr(32'hFF813203, TMO, 1'b0, "ld_timeout");
    endtask

    task automatic test_illegal();
        run_instr(32'h00000013, 0, 1'b0, "illegal_addi");
        run_instr(rand_instr(4), 0, 1'b0, "illegal_ld_f3");
        run_instr(rand_instr(5), 0, 1'b0, "illegal_f7");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++)
            run_instr(rand_instr($urandom_range(0, 6)), $urandom_range(0, TMO + 1), 1'b1, "b2b_noise");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++)
            run_instr(rand_instr($urandom_range(0, 6)), $urandom_range(0, TMO + 1), 1'b0, "random");
    endtask

    task automatic test_reset_mid_mem();
        instruction = 32'hFF813203;
        instr_valid = 1'b1;
        dm_ready    = 1'b0;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if (dm_read !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_mem dm_read before reset: got %b expected 1", dm_read);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({act_ctl(), rf_addr_a, rf_addr_b, rf_write_addr, imm, retired_count} !== {CTL_IDLE, 79'b0, CW'(0)}) begin
            n_bad++;
            $display("FAIL mid_mem reset outputs: ctl=%b imm=%h cnt=%0d expected ctl=%b, rest 0", act_ctl(), imm, retired_count, CTL_IDLE);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_cnt = 0;
        dm_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({rf_write_enable, done, instr_ready, retired_count} !== {3'b001, CW'(0)}) begin
                n_bad++;
                $display("FAIL mid_mem after reset cycle %0d: we=%b done=%b ready=%b cnt=%0d expected 0 0 1 0",
                         i, rf_write_enable, done, instr_ready, retired_count);
            end
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        @(negedge clk);
        for (int i = 0; i < (1 << CW); i++)
            run_instr(rand_instr($urandom_range(2, 3)), 0, 1'b0, "wrap");
        n_cmp++;
        if (retired_count !== CW'(0)) begin
            n_bad++;
            $display("FAIL wrap: got %0d expected 0", retired_count);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add_sub();
        test_ld();
        test_sd_timeout();
        test_illegal();
        test_reset_mid_mem();
        test_back_to_back();
        test_random();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
